// File: rtl/mem_arbiter.sv
// Multi-port byte-serial memory arbiter: grants one requester at a time and
// walks its transfer across an 8-bit RAM port, one byte per cycle.

module mem_arbiter_lane #(
  parameter int DATA_BYTES = 4,
  parameter int KW         = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic [KW-1:0]           n,
  input  logic                    wr,
  input  logic [KW-1:0]           idx,
  input  logic [7:0]              din,
  output logic [8*DATA_BYTES-1:0] data
);
  always_ff @(posedge clk) begin
    if (rst) data <= '0;
    else begin
      // bytes beyond the new read length are zeroed at grant time
      if (clr)
        for (int b = 0; b < DATA_BYTES; b++)
          if (b >= int'(n)) data[b*8 +: 8] <= 8'h00;
      if (wr) data[int'(idx)*8 +: 8] <= din;
    end
  end
endmodule

module mem_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_BYTES = 4,
  parameter int RR_MODE    = 0,
  localparam int LW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              req,
  input  logic [NUM_PORTS-1:0]              we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr,
  input  logic [NUM_PORTS*LW-1:0]           len,
  input  logic [NUM_PORTS*8*DATA_BYTES-1:0] wdata,
  output logic [NUM_PORTS*8*DATA_BYTES-1:0] rdata,
  output logic [NUM_PORTS-1:0]              done,
  output logic [NUM_PORTS-1:0]              stall,
  input  logic [7:0]                        ram_din,
  output logic [7:0]                        ram_dout,
  output logic [ADDR_WIDTH-1:0]             ram_addr,
  output logic                              ram_wr
);
  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int KW = LW + 1;
  localparam int DW = 8 * DATA_BYTES;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] LAST = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]            state;
  logic [GW-1:0]         g, last_grant, pick;
  logic [KW-1:0]         k, n, n_new;
  logic [ADDR_WIDTH-1:0] base;
  logic                  dir;
  logic [LW-1:0]         len_sel;
  logic [DW-1:0]         wdata_g;
  logic                  grant_go, cap_en;

  always_comb begin
    pick = '0;
    if (RR_MODE == 0) begin
      for (int i = 0; i < NUM_PORTS; i++)
        if (req[i]) pick = GW'(i);
    end else begin
      // walk upward from the port after the last grant, first hit wins
      for (int off = NUM_PORTS; off >= 1; off--) begin
        int idx;
        idx = (int'(last_grant) + off) % NUM_PORTS;
        if (req[idx]) pick = GW'(idx);
      end
    end
  end

  always_comb begin
    len_sel = len[pick*LW +: LW];
    if (int'(len_sel) >= DATA_BYTES) n_new = KW'(DATA_BYTES);
    else                             n_new = KW'(len_sel) + KW'(1);
  end

  assign grant_go = (state == IDLE) && (|req);
  assign cap_en   = !dir && (((state == XFER) && (k != '0)) || (state == LAST));
  assign wdata_g  = wdata[g*DW +: DW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      g          <= '0;
      n          <= '0;
      dir        <= 1'b0;
      base       <= '0;
      last_grant <= GW'(NUM_PORTS - 1);
    end else begin
      case (state)
        IDLE: if (grant_go) begin
          g          <= pick;
          last_grant <= pick;
          dir        <= we[pick];
          base       <= addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
          n          <= n_new;
          k          <= '0;
          state      <= XFER;
        end
        XFER: begin
          k <= k + KW'(1);
          if (k == n - KW'(1)) state <= dir ? DONE : LAST;
        end
        LAST:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ram_wr   = 1'b0;
    ram_dout = 8'h00;
    ram_addr = '0;
    case (state)
      XFER: begin
        ram_wr   = dir;
        ram_dout = wdata_g[int'(k)*8 +: 8];
        ram_addr = base + ADDR_WIDTH'(k);
      end
      LAST:    ram_addr = base + ADDR_WIDTH'(n) - ADDR_WIDTH'(1);
      default: ;
    endcase
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
    assign done[i]  = (state == DONE) && (g == GW'(i));
    assign stall[i] = req[i] & ~done[i];

    mem_arbiter_lane #(.DATA_BYTES(DATA_BYTES), .KW(KW)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .clr  (grant_go && (pick == GW'(i)) && !we[i]),
      .n    (n_new),
      .wr   (cap_en && (g == GW'(i))),
      .idx  (k - KW'(1)),
      .din  (ram_din),
      .data (rdata[i*DW +: DW])
    );
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: RAM-write and done-pulse scoreboards fed by
// the stimulus, plus a second round-robin instance for grant ordering.

module tb_mem_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic [1:0]  req = '0, we = '0, req_rr = '0;
  logic [63:0] addr = '0, wdata = '0;
  logic [3:0]  len = '0;
  logic [63:0] rdata, rdata_rr;
  logic [1:0]  done, stall, done_rr, stall_rr;
  logic [7:0]  ram_din = '0, ram_dout, ram_dout_rr;
  logic [31:0] ram_addr, ram_addr_rr;
  logic        ram_wr, ram_wr_rr;

  int vectors = 0, miscompares = 0, cyc = 0;

  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
  typedef struct { int port; int cyc; } dn_t;
  wr_t wq[$];
  dn_t dq[$];
  int  rq[$];
  logic [7:0] mem [logic [31:0]];

  mem_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .len(len),
    .wdata(wdata), .rdata(rdata), .done(done), .stall(stall),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_addr(ram_addr), .ram_wr(ram_wr)
  );

  mem_arbiter #(.RR_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .req(req_rr), .we(we), .addr(addr), .len(len),
    .wdata(wdata), .rdata(rdata_rr), .done(done_rr), .stall(stall_rr),
    .ram_din(ram_din), .ram_dout(ram_dout_rr), .ram_addr(ram_addr_rr), .ram_wr(ram_wr_rr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) ram_din <= mem.exists(ram_addr) ? mem[ram_addr] : 8'h00;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboards: every RAM write and every done pulse must have been predicted
  always @(negedge clk) begin
    if (ram_wr === 1'b1) begin
      vectors++;
      assert (wq.size() != 0) else begin
        miscompares++;
        $error("FAIL wr_unexpected observed=%0h expected=none", ram_addr);
      end
      if (wq.size() != 0) begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_addr", ram_addr, e.a);
        chk("wr_data", ram_dout, e.d);
      end
    end
    if (|done) begin
      vectors++;
      assert (dq.size() != 0) else begin
        miscompares++;
        $error("FAIL done_unexpected observed=%0h expected=0", done);
      end
      if (dq.size() != 0) begin
        dn_t e;
        e = dq.pop_front();
        chk("done_port", done, 64'(1 << e.port));
        chk("done_cyc", cyc, e.cyc);
      end
    end
  end

  task automatic push_exp(input int p, input bit w, input logic [31:0] a,
                          input int l, input logic [31:0] d, input int t);
    if (w) for (int b = 0; b <= l; b++) wq.push_back('{a + 32'(b), d[b*8 +: 8]});
    dq.push_back('{p, t + l + 2 + (w ? 0 : 1)});
  endtask

  task automatic start(input int p, input bit w, input logic [31:0] a,
                       input int l, input logic [31:0] d, input bit pu);
    we[p] = w;
    addr[p*32 +: 32] = a;
    len[p*2 +: 2] = 2'(l);
    wdata[p*32 +: 32] = d;
    req[p] = 1'b1;
    if (pu) push_exp(p, w, a, l, d, cyc);
  endtask

  task automatic wait_done(input int p);
    bit got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (done[p]) got = 1;
    end
    vectors++;
    assert (got) else begin
      miscompares++;
      $error("FAIL done_timeout observed=0 expected=port%0d", p);
    end
    @(posedge clk); #1;
    req[p] = 1'b0;
  endtask

  initial begin
    int t, d1, cnt;
    mem[32'h20] = 8'h11;
    mem[32'h21] = 8'h22;
    mem[32'h30] = 8'h5A;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_ram_wr", ram_wr, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_dout", ram_dout, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_stall", stall, 0);

    // 4-byte write on port 0
    @(posedge clk); #1;
    start(0, 1, 32'h100, 3, 32'hDDCCBBAA, 1);
    wait_done(0);
    chk("wr_keeps_rdata", rdata, 0);

    // 2-byte read on port 1
    start(1, 0, 32'h20, 1, 32'h0, 1);
    wait_done(1);
    chk("rd_rdata1", rdata[63:32], 32'h00002211);

    // 1-byte read clears the stale upper byte
    start(1, 0, 32'h30, 0, 32'h0, 1);
    wait_done(1);
    chk("rd_clear_rdata1", rdata[63:32], 32'h0000005A);

    // simultaneous request: fixed priority serves port 1 first
    start(1, 1, 32'h300, 1, 32'h00007766, 1);
    start(0, 1, 32'h200, 0, 32'h000000EE, 0);
    d1 = -1;
    for (int i = 0; i < 30 && d1 < 0; i++) begin
      @(negedge clk);
      chk("stall0_held", stall[0], 1);
      if (done[1]) begin
        d1 = cyc;
        chk("stall1_release", stall[1], 0);
      end
    end
    vectors++;
    assert (d1 >= 0) else begin
      miscompares++;
      $error("FAIL done1_timeout observed=none expected=pulse");
    end
    push_exp(0, 1, 32'h200, 0, 32'h000000EE, d1 + 1);
    @(posedge clk); #1;
    req[1] = 1'b0;
    wait_done(0);

    // address wraps past the top of the space
    start(0, 1, 32'hFFFFFFFE, 3, 32'h44332211, 1);
    wait_done(0);

    // request dropped mid-transfer still completes
    start(1, 1, 32'h400, 1, 32'h0000BEEF, 1);
    @(posedge clk); #1;
    req[1] = 1'b0;
    wait_done(1);

    // reset during XFER at k=2 abandons the write
    start(0, 1, 32'h500, 3, 32'h0D0C0B0A, 0);
    for (int b = 0; b < 3; b++) wq.push_back('{32'h500 + 32'(b), 8'(8'h0A + b)});
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    req = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ram_wr", ram_wr, 0);
    chk("post_rst_done", done, 0);
    chk("post_rst_ram_addr", ram_addr, 0);
    repeat (6) @(posedge clk);

    // round-robin instance: held requests alternate 0,1,0,1
    #1;
    we = 2'b11;
    len = '0;
    rq = '{0, 1, 0, 1};
    req_rr = 2'b11;
    cnt = 0;
    for (int i = 0; i < 60 && cnt < 4; i++) begin
      @(negedge clk);
      if (|done_rr) begin
        int e;
        e = rq.pop_front();
        chk("rr_grant", done_rr, 64'(1 << e));
        cnt++;
      end
    end
    @(posedge clk); #1;
    req_rr = '0;
    chk("rr_count", cnt, 4);

    repeat (4) @(posedge clk);
    chk("wq_drained", wq.size(), 0);
    chk("dq_drained", dq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
